// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with level/overrun flags; optional character timeout under UART_RX_FIFO_TIMEOUT_EN
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int WATERMARK      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_we,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    input  logic                     clr_overrun,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overrun,
    output logic                     level_irq,
    output logic                     timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of two and at least 2");
    end
    if (WATERMARK < 1 || WATERMARK > DEPTH) begin : g_wm_chk
        $error("WATERMARK must be in 1..DEPTH");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_to_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          overrun_q;
    logic          push;
    logic          pop;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign level_irq = (count_q >= CW'(WATERMARK));
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign out_data  = mem[rd_ptr];

    assign pop  = out_valid && out_ready;
    assign push = in_we && (!full || pop);

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // A byte offered during flush is discarded on purpose, so it is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (in_we && full && !pop && !flush) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES);

    logic [IW-1:0] idle_q;
    logic          timeout_q;

    always_ff @(posedge clk) begin
        if (rst || flush || push || pop) begin
            idle_q <= '0;
        end else if (out_valid && !timeout_q) begin
            idle_q <= idle_q + 1'b1;
        end
    end

    // Pushes keep the flag: stale data is still waiting at the head.
    always_ff @(posedge clk) begin
        if (rst || flush || pop) begin
            timeout_q <= 1'b0;
        end else if (idle_q == IW'(TIMEOUT_CYCLES - 1) && out_valid) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - table-driven bench for uart_rx_fifo (DEPTH=4, WATERMARK=2, TIMEOUT_CYCLES=8)
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_we;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       flush;
    logic       clr_overrun;
    logic [2:0] count;
    logic       full;
    logic       overrun;
    logic       level_irq;
    logic       timeout;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(4), .WATERMARK(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_we(in_we),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .clr_overrun(clr_overrun), .count(count), .full(full),
        .overrun(overrun), .level_irq(level_irq), .timeout(timeout)
    );

    typedef struct {
        logic       rst, we;
        logic [7:0] din;
        logic       rdy, fl, clr;
        logic [2:0] cnt;
        logic       vld;
        logic [7:0] dat;
        logic       full, ovr, irq;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic w, input logic [7:0] d,
                                input logic rd, input logic f, input logic c,
                                input logic [2:0] cn, input logic v, input logic [7:0] dt,
                                input logic fu, input logic o, input logic i);
        vec_t e;
        e.rst = r; e.we = w; e.din = d; e.rdy = rd; e.fl = f; e.clr = c;
        e.cnt = cn; e.vld = v; e.dat = dt; e.full = fu; e.ovr = o; e.irq = i;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s step %0d: got %02h expected %02h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] d,
                         input logic rd, input logic f, input logic c);
        rst = r; in_we = w; in_data = d; out_ready = rd; flush = f; clr_overrun = c;
        @(posedge clk);
        #1;
        rst = 1'b0; in_we = 1'b0; out_ready = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_we = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        flush = 1'b0; clr_overrun = 1'b0;

        //  rst we din   rdy fl clr  cnt vld dat  full ovr irq
        add(1, 0, 8'h00, 0, 0, 0,   0, 0, 8'h00, 0, 0, 0);
        // basic push then pop, plus pop on empty ignored
        add(0, 1, 8'hA5, 0, 0, 0,   1, 1, 8'hA5, 0, 0, 0);
        add(0, 1, 8'h3C, 0, 0, 0,   2, 1, 8'hA5, 0, 0, 1);
        add(0, 0, 8'h00, 1, 0, 0,   1, 1, 8'h3C, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0,   0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0,   0, 0, 8'h00, 0, 0, 0);
        // fill, overrun with simultaneous clr (set wins), drain
        add(0, 1, 8'h01, 0, 0, 0,   1, 1, 8'h01, 0, 0, 0);
        add(0, 1, 8'h02, 0, 0, 0,   2, 1, 8'h01, 0, 0, 1);
        add(0, 1, 8'h03, 0, 0, 0,   3, 1, 8'h01, 0, 0, 1);
        add(0, 1, 8'h04, 0, 0, 0,   4, 1, 8'h01, 1, 0, 1);
        add(0, 1, 8'h05, 0, 0, 1,   4, 1, 8'h01, 1, 1, 1);
        add(0, 0, 8'h00, 1, 0, 0,   3, 1, 8'h02, 0, 1, 1);
        add(0, 0, 8'h00, 1, 0, 0,   2, 1, 8'h03, 0, 1, 1);
        add(0, 0, 8'h00, 1, 0, 0,   1, 1, 8'h04, 0, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0,   0, 0, 8'h00, 0, 1, 0);
        // flush keeps overrun; clr_overrun clears it
        add(0, 1, 8'h66, 0, 0, 0,   1, 1, 8'h66, 0, 1, 0);
        add(0, 1, 8'h77, 0, 1, 0,   0, 0, 8'h00, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 8'h00, 0, 0, 0);
        // full with simultaneous push and pop, pointer wrap
        add(0, 1, 8'h01, 0, 0, 0,   1, 1, 8'h01, 0, 0, 0);
        add(0, 1, 8'h02, 0, 0, 0,   2, 1, 8'h01, 0, 0, 1);
        add(0, 1, 8'h03, 0, 0, 0,   3, 1, 8'h01, 0, 0, 1);
        add(0, 1, 8'h04, 0, 0, 0,   4, 1, 8'h01, 1, 0, 1);
        add(0, 1, 8'h55, 1, 0, 0,   4, 1, 8'h02, 1, 0, 1);
        add(0, 0, 8'h00, 1, 0, 0,   3, 1, 8'h03, 0, 0, 1);
        add(0, 0, 8'h00, 1, 0, 0,   2, 1, 8'h04, 0, 0, 1);
        add(0, 0, 8'h00, 1, 0, 0,   1, 1, 8'h55, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0,   0, 0, 8'h00, 0, 0, 0);
        // flush beats simultaneous push and pop
        add(0, 1, 8'h11, 0, 0, 0,   1, 1, 8'h11, 0, 0, 0);
        add(0, 1, 8'h22, 0, 0, 0,   2, 1, 8'h11, 0, 0, 1);
        add(0, 1, 8'h33, 0, 0, 0,   3, 1, 8'h11, 0, 0, 1);
        add(0, 1, 8'h99, 1, 1, 0,   0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h7E, 0, 0, 0,   1, 1, 8'h7E, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0,   0, 0, 8'h00, 0, 0, 0);
        // reset mid-stream with 2 entries and overrun set
        add(0, 1, 8'h01, 0, 0, 0,   1, 1, 8'h01, 0, 0, 0);
        add(0, 1, 8'h02, 0, 0, 0,   2, 1, 8'h01, 0, 0, 1);
        add(0, 1, 8'h03, 0, 0, 0,   3, 1, 8'h01, 0, 0, 1);
        add(0, 1, 8'h04, 0, 0, 0,   4, 1, 8'h01, 1, 0, 1);
        add(0, 1, 8'h05, 0, 0, 0,   4, 1, 8'h01, 1, 1, 1);
        add(0, 0, 8'h00, 1, 0, 0,   3, 1, 8'h02, 0, 1, 1);
        add(0, 0, 8'h00, 1, 0, 0,   2, 1, 8'h03, 0, 1, 1);
        add(1, 1, 8'hAA, 1, 0, 0,   0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'hC3, 0, 0, 0,   1, 1, 8'hC3, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0,   0, 0, 8'h00, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].din, tbl[i].rdy, tbl[i].fl, tbl[i].clr);
            chk("count",     i, {5'd0, count},     {5'd0, tbl[i].cnt});
            chk("out_valid", i, {7'd0, out_valid}, {7'd0, tbl[i].vld});
            chk("full",      i, {7'd0, full},      {7'd0, tbl[i].full});
            chk("overrun",   i, {7'd0, overrun},   {7'd0, tbl[i].ovr});
            chk("level_irq", i, {7'd0, level_irq}, {7'd0, tbl[i].irq});
            chk("timeout",   i, {7'd0, timeout},   8'd0);
            if (tbl[i].vld) begin
                chk("out_data", i, out_data, tbl[i].dat);
            end
        end

        // character timeout: push once, then stay idle with out_ready low
        drive(0, 1, 8'h42, 0, 0, 0);
        chk("to_count", 100, {5'd0, count}, 8'd1);
        for (int c = 1; c <= 8; c++) begin
            drive(0, 0, 8'h00, 0, 0, 0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
            chk("timeout_idle", 100 + c, {7'd0, timeout}, (c == 8) ? 8'd1 : 8'd0);
`else
            chk("timeout_idle", 100 + c, {7'd0, timeout}, 8'd0);
`endif
        end
        drive(0, 1, 8'h43, 0, 0, 0);
        chk("to_push_count", 110, {5'd0, count}, 8'd2);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        chk("timeout_after_push", 110, {7'd0, timeout}, 8'd1);
`else
        chk("timeout_after_push", 110, {7'd0, timeout}, 8'd0);
`endif
        drive(0, 0, 8'h00, 1, 0, 0);
        chk("timeout_after_pop", 111, {7'd0, timeout}, 8'd0);
        chk("to_pop_data", 111, out_data, 8'h43);
        drive(0, 0, 8'h00, 1, 0, 0);
        chk("to_drain_count", 112, {5'd0, count}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
